exec_sequencer: RTL

Multi-cycle execute controller for the calculator datapath. Accepts one operation at a time over a valid/ready handshake, evaluates its condition code against the current flags, reads two operands from the register file, drives the ALU, and writes back the result and the new ZNCV flags. It is the only writer of the flags register's write strobe and the register file write port.

---
 rtl/gpp_pkg.sv | 31 +++
 rtl/exec_sequencer_if.sv | 59 +++++
 rtl/exec_sequencer_cond_eval.sv | 30 +++
 rtl/exec_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gpp_pkg.sv
// gpp_pkg
// Shared definitions for the calculator datapath control blocks:
//   - state_t      : execute sequencer state encoding
//   - COND_*       : condition code values carried on req_cond
//   - FLG_*        : bit positions of Z/N/C/V inside every 4-bit flags vector
package gpp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COND,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_t;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CS = 3'd3;
  localparam logic [2:0] COND_CC = 3'd4;
  localparam logic [2:0] COND_MI = 3'd5;
  localparam logic [2:0] COND_GE = 3'd6;
  localparam logic [2:0] COND_LT = 3'd7;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if
// Bundles every non-clock/reset signal of the execute sequencer.
//   master : the sequencer itself (drives handshake ready, register file
//            addresses/write port, ALU inputs, flags write port, status)
//   slave  : the surrounding datapath (drives requests, read data, ALU
//            results and the current flags)
interface exec_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 3
);

  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [2:0]    req_cond;
  logic          req_wb;
  logic          req_wf;
  logic [AW-1:0] req_rd;
  logic [AW-1:0] req_ra;
  logic [AW-1:0] req_rb;

  logic [AW-1:0] rf_ra_addr;
  logic [AW-1:0] rf_rb_addr;
  logic [DW-1:0] rf_ra_data;
  logic [DW-1:0] rf_rb_data;

  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic [3:0]    alu_flags;

  logic [3:0]    flags_in;
  logic          flags_w;
  logic [3:0]    flags_d;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  logic          done;
  logic          skipped;
  logic          busy;

  modport master (
    input  req_valid, req_op, req_cond, req_wb, req_wf, req_rd, req_ra, req_rb,
    input  rf_ra_data, rf_rb_data, alu_res, alu_flags, flags_in,
    output req_ready, rf_ra_addr, rf_rb_addr, alu_op, alu_a, alu_b,
    output flags_w, flags_d, rf_we, rf_waddr, rf_wdata, done, skipped, busy
  );

  modport slave (
    output req_valid, req_op, req_cond, req_wb, req_wf, req_rd, req_ra, req_rb,
    output rf_ra_data, rf_rb_data, alu_res, alu_flags, flags_in,
    input  req_ready, rf_ra_addr, rf_rb_addr, alu_op, alu_a, alu_b,
    input  flags_w, flags_d, rf_we, rf_waddr, rf_wdata, done, skipped, busy
  );

endinterface

// File: rtl/exec_sequencer_cond_eval.sv
// cond_eval
// Combinational condition-code check.
//   cond  in  3  condition code (COND_AL..COND_LT)
//   flags in  4  {Z,N,C,V}
//   pass  out 1  condition holds
module cond_eval
  import gpp_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  // One case arm per code; GE/LT compare N against V for signed ordering.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = flags[FLG_Z];
      COND_NE: pass = !flags[FLG_Z];
      COND_CS: pass = flags[FLG_C];
      COND_CC: pass = !flags[FLG_C];
      COND_MI: pass = flags[FLG_N];
      COND_GE: pass = (flags[FLG_N] == flags[FLG_V]);
      COND_LT: pass = (flags[FLG_N] != flags[FLG_V]);
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Multi-cycle execute controller: accepts one op over valid/ready, checks
// its condition against the flags, reads two operands, drives the ALU and
// writes back result and flags.
//   clk  in  clock, rising edge
//   rst  in  asynchronous, active-low reset
//   bus  exec_sequencer_if.master : handshake, register file, ALU, flags, status
module exec_sequencer
  import gpp_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                rst,
  exec_sequencer_if.master    bus
);

  state_t        state_q;

  logic [3:0]    op_q;
  logic [2:0]    cond_q;
  logic          wb_q;
  logic          wf_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] ra_q;
  logic [AW-1:0] rb_q;
  logic          skip_q;
  logic [DW-1:0] res_q;
  logic [3:0]    flg_q;

  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          skipped_q;
  logic          rf_we_q;
  logic          flags_w_q;
  logic [AW-1:0] ra_addr_q;
  logic [AW-1:0] rb_addr_q;
  logic [3:0]    alu_op_q;
  logic          exec_q;
  logic          wb_phase_q;

  logic          cond_pass;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (bus.flags_in),
    .pass  (cond_pass)
  );

  // Sequencer FSM. Every output flag is set on the transition into the state
  // that owns it, so status and strobes come straight from flops. Reset
  // clears rf_we/flags_w asynchronously, so a WB cycle cut short never writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      cond_q     <= '0;
      wb_q       <= 1'b0;
      wf_q       <= 1'b0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      skip_q     <= 1'b0;
      res_q      <= '0;
      flg_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      skipped_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      flags_w_q  <= 1'b0;
      ra_addr_q  <= '0;
      rb_addr_q  <= '0;
      alu_op_q   <= '0;
      exec_q     <= 1'b0;
      wb_phase_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            cond_q  <= bus.req_cond;
            wb_q    <= bus.req_wb;
            wf_q    <= bus.req_wf;
            rd_q    <= bus.req_rd;
            ra_q    <= bus.req_ra;
            rb_q    <= bus.req_rb;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_COND;
          end
        end
        ST_COND: begin
          if (cond_pass) begin
            ra_addr_q <= ra_q;
            rb_addr_q <= rb_q;
            state_q   <= ST_READ;
          end else begin
            skip_q    <= 1'b1;
            done_q    <= 1'b1;
            skipped_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_READ: begin
          alu_op_q <= op_q;
          exec_q   <= 1'b1;
          state_q  <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q      <= bus.alu_res;
          flg_q      <= bus.alu_flags;
          alu_op_q   <= '0;
          exec_q     <= 1'b0;
          ra_addr_q  <= '0;
          rb_addr_q  <= '0;
          rf_we_q    <= wb_q;
          flags_w_q  <= wf_q;
          wb_phase_q <= 1'b1;
          state_q    <= ST_WB;
        end
        ST_WB: begin
          rf_we_q    <= 1'b0;
          flags_w_q  <= 1'b0;
          wb_phase_q <= 1'b0;
          done_q     <= 1'b1;
          skipped_q  <= skip_q;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          done_q    <= 1'b0;
          skipped_q <= 1'b0;
          skip_q    <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand data only becomes valid in EXEC, so the ALU inputs are gated
  // from the register file read data rather than registered.
  assign bus.alu_a      = exec_q ? bus.rf_ra_data : '0;
  assign bus.alu_b      = exec_q ? bus.rf_rb_data : '0;
  assign bus.alu_op     = alu_op_q;
  assign bus.rf_ra_addr = ra_addr_q;
  assign bus.rf_rb_addr = rb_addr_q;

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = wb_phase_q ? rd_q  : '0;
  assign bus.rf_wdata   = wb_phase_q ? res_q : '0;
  assign bus.flags_w    = flags_w_q;
  assign bus.flags_d    = wb_phase_q ? flg_q : '0;

  assign bus.req_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.skipped    = skipped_q;

endmodule
